dsk_fetch_engine: RTL and testbench

- Requester-side counterpart of the floppy-image slot that the address controller grants (dskReadAddrInt/dskReadAckInt or the Ext pair).
- Holds a word address on the slot address bus and captures the 16-bit memory word when its slot is acked and latched.
- Buffers captured words in a small prefetch FIFO and delivers a big-endian byte stream to the IWM/disk-drive logic over a valid/ready handshake.
- One instance per drive: internal image at 1MB, external at 2MB. The address controller adds those offsets, so this block works in image-relative addresses.

---
 rtl/dsk_fetch_engine_pkg.sv | 21 ++
 rtl/dsk_word_fifo.sv | 64 ++++++
 rtl/dsk_fetch_engine.sv | 128 ++++++++++++
 tb/tb_dsk_fetch_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsk_fetch_engine_pkg.sv
// Shared definitions for the floppy-image fetch path.
// Image base offsets are applied by the address controller, so the fetch
// engine itself only ever works with image-relative addresses.
package dsk_fetch_engine_pkg;

    localparam logic [21:0] DSK_INT_BASE = 22'h100000;
    localparam logic [21:0] DSK_EXT_BASE = 22'h200000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of 16-bit words covering 'count' bytes when the first byte sits
    // at an odd address (the leading high byte of that word is skipped).
    function automatic logic [16:0] words_for(input logic [15:0] count,
                                              input logic        odd);
        return ({1'b0, count} + {16'd0, odd} + 17'd1) >> 1;
    endfunction

endpackage

// File: rtl/dsk_word_fifo.sv
// Synchronous word FIFO for the fetch engine's prefetch buffer.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   push, din        write a word (ignored when full)
//   pop              drop the head word (ignored when empty)
//   flush            empty the FIFO; wins over push/pop on the same clk
//   full, empty      occupancy flags
//   head             word at the read pointer (undefined when empty)
module dsk_word_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [15:0] din,
    output logic        full,
    output logic        empty,
    output logic [15:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dsk_fetch_engine.sv
// Requester side of one drive's floppy-image memory slot.
// Presents a word address to the address controller, captures the word when
// the slot is acked and latched, buffers it in a small FIFO and streams it out
// as big-endian bytes over a valid/ready handshake.
// Ports:
//   clk, _reset                         clock, async active-low reset
//   memoryLatch, dskReadAck, memoryDataIn  slot handshake and read data
//   dskReadAddr                         image-relative word address (bit0 = 0)
//   start, startAddr, byteCount         transfer request (start aborts any run)
//   busy                                transfer in progress
//   byteOut, byteValid, byteReady       byte stream to the IWM/drive logic
//
// state | meaning
// IDLE  | no transfer; slots are ignored, no bytes presented
// RUN   | fetching words on acked slots and delivering bytes
module dsk_fetch_engine
    import dsk_fetch_engine_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 22
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              memoryLatch,
    input  logic              dskReadAck,
    input  logic [15:0]       memoryDataIn,
    output logic [ADDR_W-1:0] dskReadAddr,
    input  logic              start,
    input  logic [ADDR_W-1:0] startAddr,
    input  logic [15:0]       byteCount,
    output logic              busy,
    output logic [7:0]        byteOut,
    output logic              byteValid,
    input  logic              byteReady
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] read_addr;
    logic [15:0]       bytes_left;
    logic [16:0]       words_left;
    logic              skip_first;
    logic              byte_ptr;

    logic              fifo_full;
    logic              fifo_empty;
    logic [15:0]       fifo_head;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;

    logic              capture;
    logic              fire;
    logic              last_byte;
    logic              ptr_lo;

    // A slot that lands on the same clk as start belongs to the old transfer
    // and is dropped; a full FIFO leaves the address put so the word is refetched.
    assign capture   = (state == RUN) && dskReadAck && memoryLatch && !fifo_full
                       && (words_left != 17'd0) && !start;
    assign byteValid = (state == RUN) && !fifo_empty && (bytes_left != 16'd0);
    assign fire      = byteValid && byteReady && !start;
    assign last_byte = (bytes_left == 16'd1);
    // An odd start enters the first word at its low byte.
    assign ptr_lo    = byte_ptr | skip_first;
    assign byteOut   = byteValid ? (ptr_lo ? fifo_head[7:0] : fifo_head[15:8]) : 8'h00;

    assign fifo_push  = capture;
    assign fifo_pop   = fire && (ptr_lo || last_byte);
    assign fifo_flush = start || (fire && last_byte);

    assign busy        = (state == RUN);
    assign dskReadAddr = read_addr;

    dsk_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (_reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (memoryDataIn),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = (byteCount != 16'd0) ? RUN : IDLE;
        else if (fire && last_byte)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            read_addr  <= '0;
            bytes_left <= '0;
            words_left <= '0;
            skip_first <= 1'b0;
            byte_ptr   <= 1'b0;
        end else if (start) begin
            read_addr  <= {startAddr[ADDR_W-1:1], 1'b0};
            bytes_left <= byteCount;
            words_left <= words_for(byteCount, startAddr[0]);
            skip_first <= startAddr[0];
            byte_ptr   <= 1'b0;
        end else begin
            if (capture) begin
                read_addr  <= read_addr + ADDR_W'(2);
                words_left <= words_left - 17'd1;
            end
            if (fire) begin
                bytes_left <= bytes_left - 16'd1;
                skip_first <= 1'b0;
                byte_ptr   <= (ptr_lo || last_byte) ? 1'b0 : 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dsk_fetch_engine.sv
module tb_dsk_fetch_engine;

    logic        clk = 1'b0;
    logic        _reset;
    logic        memoryLatch;
    logic        dskReadAck;
    logic [15:0] memoryDataIn;
    logic [21:0] dskReadAddr;
    logic        start;
    logic [21:0] startAddr;
    logic [15:0] byteCount;
    logic        busy;
    logic [7:0]  byteOut;
    logic        byteValid;
    logic        byteReady;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;

    always #5 clk = ~clk;

    dsk_fetch_engine #(
        .FIFO_DEPTH (4),
        .ADDR_W     (22)
    ) dut (
        .clk          (clk),
        ._reset       (_reset),
        .memoryLatch  (memoryLatch),
        .dskReadAck   (dskReadAck),
        .memoryDataIn (memoryDataIn),
        .dskReadAddr  (dskReadAddr),
        .start        (start),
        .startAddr    (startAddr),
        .byteCount    (byteCount),
        .busy         (busy),
        .byteOut      (byteOut),
        .byteValid    (byteValid),
        .byteReady    (byteReady)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [21:0] addr, input logic [15:0] cnt);
        start     = 1'b1;
        startAddr = addr;
        byteCount = cnt;
        tick(1);
        start     = 1'b0;
    endtask

    // One memory slot: ack for 3 clks with the latch in the middle.
    task automatic slot(input logic [15:0] word);
        dskReadAck   = 1'b1;
        tick(1);
        memoryLatch  = 1'b1;
        memoryDataIn = word;
        tick(1);
        memoryLatch  = 1'b0;
        tick(1);
        dskReadAck   = 1'b0;
        tick(1);
    endtask

    task automatic push_bytes(input logic [15:0] w, input bit hi, input bit lo);
        if (hi) exp_q.push_back(w[15:8]);
        if (lo) exp_q.push_back(w[7:0]);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && busy; i++) tick(1);
        chk(name, {31'd0, busy}, 32'd0);
        chk({name, "_drained"}, exp_q.size(), 32'd0);
    endtask

    // Scoreboard monitor: every accepted byte must match the next expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (_reset && byteValid && byteReady) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_byte: got %02h expected none at %0t", byteOut, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("byte", {24'd0, byteOut}, {24'd0, mon_exp});
                end
            end
        end
    end

    initial begin
        _reset       = 1'b0;
        memoryLatch  = 1'b0;
        dskReadAck   = 1'b0;
        memoryDataIn = 16'h0000;
        start        = 1'b0;
        startAddr    = '0;
        byteCount    = '0;
        byteReady    = 1'b1;
        tick(3);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_valid", {31'd0, byteValid}, 32'd0);
        chk("rst_byte",  {24'd0, byteOut},   32'd0);
        chk("rst_addr",  {10'd0, dskReadAddr}, 32'd0);
        _reset = 1'b1;
        tick(2);

        // Even start, short transfer
        push_bytes(16'h1234, 1, 1);
        push_bytes(16'h5678, 1, 1);
        do_start(22'h000200, 16'd4);
        chk("t1_addr0", {10'd0, dskReadAddr}, 32'h200);
        chk("t1_busy",  {31'd0, busy}, 32'd1);
        slot(16'h1234);
        chk("t1_addr1", {10'd0, dskReadAddr}, 32'h202);
        dskReadAck   = 1'b1;
        tick(1);
        memoryLatch  = 1'b1;
        memoryDataIn = 16'h5678;
        tick(1);
        memoryLatch  = 1'b0;
        chk("t1_addr2", {10'd0, dskReadAddr}, 32'h204);
        chk("t1_busy_b56", {31'd0, busy}, 32'd1);
        tick(1);
        chk("t1_busy_b78", {31'd0, busy}, 32'd1);
        tick(1);
        dskReadAck = 1'b0;
        chk("t1_busy_fall", {31'd0, busy}, 32'd0);
        chk("t1_drained", exp_q.size(), 32'd0);
        tick(2);

        // Odd start, odd count: AA never presented, two captures only
        push_bytes(16'hAABB, 0, 1);
        push_bytes(16'hCCDD, 1, 1);
        do_start(22'h000201, 16'd3);
        chk("t2_addr0", {10'd0, dskReadAddr}, 32'h200);
        slot(16'hAABB);
        chk("t2_addr1", {10'd0, dskReadAddr}, 32'h202);
        slot(16'hCCDD);
        chk("t2_addr2", {10'd0, dskReadAddr}, 32'h204);
        slot(16'hEEFF);
        chk("t2_no3rd", {10'd0, dskReadAddr}, 32'h204);
        wait_idle("t2_idle");

        // FIFO full with consumer stalled
        byteReady = 1'b0;
        push_bytes(16'h0102, 1, 1);
        push_bytes(16'h0304, 1, 1);
        push_bytes(16'h0506, 1, 1);
        push_bytes(16'h0708, 1, 1);
        push_bytes(16'h090A, 1, 1);
        do_start(22'h000000, 16'd10);
        slot(16'h0102);
        slot(16'h0304);
        slot(16'h0506);
        slot(16'h0708);
        chk("t3_addr4", {10'd0, dskReadAddr}, 32'h008);
        slot(16'hDEAD);
        chk("t3_full_hold", {10'd0, dskReadAddr}, 32'h008);
        byteReady = 1'b1;
        tick(10);
        chk("t3_after_drain", {10'd0, dskReadAddr}, 32'h008);
        chk("t3_left", exp_q.size(), 32'd2);
        slot(16'h090A);
        chk("t3_refetch", {10'd0, dskReadAddr}, 32'h00A);
        wait_idle("t3_idle");

        // Restart mid-transfer, coinciding with a capture
        byteReady = 1'b0;
        push_bytes(16'h1122, 1, 1);
        push_bytes(16'h3344, 1, 0);
        do_start(22'h001000, 16'd100);
        slot(16'h1122);
        slot(16'h3344);
        slot(16'h5566);
        chk("t4_addr3", {10'd0, dskReadAddr}, 32'h1006);
        byteReady = 1'b1;
        tick(3);
        byteReady = 1'b0;
        chk("t4_three", exp_q.size(), 32'd0);
        dskReadAck   = 1'b1;
        tick(1);
        memoryLatch  = 1'b1;
        memoryDataIn = 16'h7788;
        start        = 1'b1;
        startAddr    = 22'h003000;
        byteCount    = 16'd2;
        tick(1);
        memoryLatch  = 1'b0;
        start        = 1'b0;
        dskReadAck   = 1'b0;
        chk("t4_restart_addr", {10'd0, dskReadAddr}, 32'h3000);
        chk("t4_flushed", {31'd0, byteValid}, 32'd0);
        push_bytes(16'hABCD, 1, 1);
        byteReady = 1'b1;
        slot(16'hABCD);
        chk("t4_addr_next", {10'd0, dskReadAddr}, 32'h3002);
        wait_idle("t4_idle");

        // Zero length
        do_start(22'h000400, 16'd0);
        chk("t5_zero_busy", {31'd0, busy}, 32'd0);
        slot(16'h9999);
        chk("t5_zero_addr", {10'd0, dskReadAddr}, 32'h400);
        chk("t5_zero_busy2", {31'd0, busy}, 32'd0);

        // Address wrap
        push_bytes(16'hA1B2, 1, 1);
        push_bytes(16'hC3D4, 1, 1);
        do_start(22'h3FFFFE, 16'd4);
        chk("t5_wrap0", {10'd0, dskReadAddr}, 32'h3FFFFE);
        slot(16'hA1B2);
        chk("t5_wrap1", {10'd0, dskReadAddr}, 32'h000000);
        slot(16'hC3D4);
        chk("t5_wrap2", {10'd0, dskReadAddr}, 32'h000002);
        wait_idle("t5_idle");

        // Async reset mid-RUN
        byteReady = 1'b0;
        do_start(22'h000800, 16'd6);
        slot(16'h1357);
        chk("t6_pre_valid", {31'd0, byteValid}, 32'd1);
        dskReadAck = 1'b1;
        #2;
        _reset = 1'b0;
        #1;
        chk("t6_busy",  {31'd0, busy},      32'd0);
        chk("t6_valid", {31'd0, byteValid}, 32'd0);
        chk("t6_byte",  {24'd0, byteOut},   32'd0);
        chk("t6_addr",  {10'd0, dskReadAddr}, 32'd0);
        tick(1);
        _reset     = 1'b1;
        dskReadAck = 1'b0;
        byteReady  = 1'b1;
        tick(1);
        slot(16'h2468);
        chk("t6_no_cap_addr", {10'd0, dskReadAddr}, 32'd0);
        chk("t6_no_cap_busy", {31'd0, busy}, 32'd0);
        push_bytes(16'h5A5B, 1, 1);
        do_start(22'h000010, 16'd2);
        slot(16'h5A5B);
        chk("t6_recover_addr", {10'd0, dskReadAddr}, 32'h012);
        wait_idle("t6_idle");

        tick(3);
        chk("final_queue", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
